div255_rem: RTL and testbench

DIV255_REM -- requirements
Module: div255_rem

---
 rtl/div255_pkg.sv | 15 +
 rtl/mul255_serial.sv | 34 +++
 rtl/div255_rem.sv | 106 ++++++++++
 tb/tb_div255_rem.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/div255_pkg.sv
// Shared constants and FSM encoding for the divide-by-255 remainder checker.
package div255_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIVISOR   = 255;
  localparam int MUL_STEPS = 8;
  localparam int STEP_W    = $clog2(MUL_STEPS);

endpackage

// File: rtl/mul255_serial.sv
// Serial shift-add multiplier: builds q*255 as the sum of q<<i for i = 0..7, one term per cycle.
module mul255_serial
  import div255_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_step,
  input  logic [STEP_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_q,
  output logic [DATA_W+7:0] o_acc
);

  logic [DATA_W+7:0] r_acc;
  logic [DATA_W+7:0] w_addend;

  // 8 guard bits hold the full 255*q product, so the running sum never wraps.
  assign w_addend = {8'b0, i_q} << i_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= r_acc + w_addend;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/div255_rem.sv
// Checks a divide-by-255 result: computes r = x - 255*q and flags q != floor(x/255).
module div255_rem
  import div255_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              done,
  output logic [7:0]        r,
  output logic              err
);

  localparam logic signed [DATA_W+8:0] MAX_REM = (DATA_W+9)'(DIVISOR - 1);
  localparam logic [STEP_W-1:0]        LAST_STEP = STEP_W'(MUL_STEPS - 1);

  // Packs {err, r}: any difference outside 0..254 means q was not the floor quotient.
  function automatic logic [8:0] rem_check(input logic signed [DATA_W+8:0] d);
    if (d[DATA_W+8] || (d > MAX_REM)) begin
      return {1'b1, 8'h00};
    end
    return {1'b0, d[7:0]};
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [DATA_W-1:0]        r_x;
  logic [DATA_W-1:0]        r_q;
  logic [STEP_W-1:0]        r_cnt;
  logic [7:0]               r_rem;
  logic                     r_err;
  logic                     w_clr;
  logic                     w_step;
  logic [DATA_W+7:0]        w_acc;
  logic signed [DATA_W+8:0] w_diff;
  logic [8:0]               w_chk;

  mul255_serial #(.DATA_W(DATA_W)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_step (w_step),
    .i_idx  (r_cnt),
    .i_q    (r_q),
    .o_acc  (w_acc)
  );

  assign w_diff = $signed({9'b0, r_x}) - $signed({1'b0, w_acc});
  assign w_chk  = rem_check(w_diff);

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clr       = 1'b1;
          w_state_nxt = MUL;
        end
      end
      MUL: begin
        w_step = 1'b1;
        if (r_cnt == LAST_STEP) w_state_nxt = SUB;
      end
      SUB:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x   <= x;
            r_q   <= q;
            r_cnt <= '0;
          end
        end
        MUL: r_cnt <= r_cnt + 1'b1;
        SUB: {r_err, r_rem} <= w_chk;
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign r    = r_rem;
  assign err  = r_err;

endmodule

// File: tb/tb_div255_rem.sv
// Directed and randomized checks of div255_rem against an arithmetic reference.
module tb_div255_rem;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] x;
  logic [31:0] q;
  logic        busy;
  logic        done;
  logic [7:0]  r;
  logic        err;

  int n_cmp;
  int n_fail;

  div255_rem #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .r     (r),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: remainder from plain 64-bit arithmetic; valid only when 0 <= x-255q <= 254.
  function automatic logic [8:0] ref_rem(input logic [31:0] xi, input logic [31:0] qi);
    longint xv, qv, d;
    xv = longint'({32'b0, xi});
    qv = longint'({32'b0, qi});
    d  = xv - 255 * qv;
    if (d < 0 || d > 254) return {1'b1, 8'h00};
    return {1'b0, d[7:0]};
  endfunction

  // Start one operation; optionally pulse start with different operands at cycle inj_at.
  task automatic run_op(input logic [31:0] xi, input logic [31:0] qi, input int inj_at,
                        input string tag);
    logic [8:0] e;
    int lat;
    e     = ref_rem(xi, qi);
    x     = xi;
    q     = qi;
    start = 1'b1;
    lat   = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
      end
      if (inj_at > 0 && lat == inj_at) begin
        start = 1'b1;
        x     = ~xi;
        q     = qi ^ 32'h5;
      end else if (inj_at > 0 && lat == inj_at + 1) begin
        start = 1'b0;
      end
      if (done) break;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd10);
    chk({tag, "_r"},   {56'b0, r}, {56'b0, e[7:0]});
    chk({tag, "_err"}, {63'b0, err}, {63'b0, e[8]});
    @(posedge clk);
    #1;
    chk({tag, "_done1"}, {62'b0, done, busy}, 64'd0);
    chk({tag, "_hold"}, {55'b0, err, r}, {55'b0, e});
  endtask

  initial begin
    logic [31:0] rq, rx;
    longint      xl;
    int          off;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    x      = '0;
    q      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {52'b0, busy, done, err, 1'b0, r}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(32'd13, 32'd0, -1, "x13");
    run_op(32'd47619, 32'd186, -1, "b2b_a");
    run_op(32'd24760, 32'd97, -1, "b2b_b");
    run_op(32'd510, 32'd3, -1, "neg");
    run_op(32'd512, 32'd1, -1, "d257");
    run_op(32'hFFFF_FFFF, 32'd16843009, -1, "maxx");
    run_op(32'd0, 32'hFFFF_FFFF, -1, "maxq");
    run_op(32'd1000, 32'd3, 3, "ignore");

    // Reset while the FSM sits in SUB: the pending result must be dropped.
    x     = 32'd2000;
    q     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_abort_busy", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_state", {52'b0, busy, done, err, 1'b0, r}, 64'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("abort_nodone", {63'b0, done}, 64'd0);
    end

    // Reset and start together: reset wins, no operation begins.
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_prio", {63'b0, busy}, 64'd0);

    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 3) begin
        rx = $urandom;
        rq = $urandom;
      end else begin
        rq  = $urandom_range(0, 16843009);
        off = int'($urandom_range(0, 263)) - 3;
        xl  = longint'({32'b0, rq}) * 255 + longint'(off);
        if (xl < 0 || xl > 64'sh0000_0000_FFFF_FFFF) rx = $urandom;
        else rx = xl[31:0];
      end
      run_op(rx, rq, -1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
